multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised, multi-channel successor to the fixed 1 kHz divider. It generates N_CH independent divided clocks (`div_clk`) plus single-cycle tick strobes (`tick`) from the 100 MHz system clock. Divisors are runtime-programmable through a write port with glitch-free, wrap-aligned update. Per-channel enables and a global phase-sync input let the display-refresh, debounce and game-timing logic share one block.

## Interface

Parameters:
- N_CH, 4, number of independent channels (≥1)
- DIV_W, 28, divisor/counter width in bits
- DEFAULT_DIV, 100000, divisor loaded at reset (1 kHz from 100 MHz); must be ≥2 and < 2^DIV_W
- CH_W, max(1, clog2(N_CH)), width of channel select (derived, not overridden)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous reset
- en  in  N_CH  per-channel count enable
- sync_all  in  1  restart all channels in phase
- wr_en  in  1  divisor write strobe
- wr_ch  in  CH_W  channel targeted by write
- wr_div  in  DIV_W  new divisor value
- div_clk  out  N_CH  divided clock per channel, registered
- tick  out  N_CH  one-cycle strobe per period, registered
- pending  out  N_CH  shadow divisor written but not yet active

## Operation

Per-channel state: counter `cnt` (DIV_W), active divisor `D`, shadow divisor `S`, flag `pending`.

- Priority: reset > sync_all > normal counting. Writes are processed in every non-reset cycle.
- Reset: cnt=0, D=S=DEFAULT_DIV, pending=0, div_clk=0, tick=0 on all channels.
- Write: when wr_en=1 and wr_ch<N_CH, S[wr_ch] ← clamp(wr_div) and pending[wr_ch] ← 1.
  - clamp: values 0 or 1 are stored as 2.
  - wr_ch ≥ N_CH: write ignored, no state change.
  - Back-to-back writes: the last write before a wrap wins.
- Normal cycle, en[i]=1, all comparisons on pre-edge values:
  - If cnt ≥ D−1 (wrap): cnt ← 0 and tick ← 1. If pending=1, then D ← S and pending ← 0.
  - Otherwise: cnt ← cnt+1, tick ← 0.
  - div_clk ← (cnt < D>>1).
- en[i]=0: cnt, D and div_clk hold; tick ← 0. A pending divisor stays pending.
- sync_all=1, all channels regardless of en: cnt ← 0, tick ← 0, div_clk ← 0. If pending=1, then D ← S and pending ← 0.
- Write coinciding with a wrap or sync_all on the same channel:
  - The transfer uses the pre-edge S and pending.
  - The new value then lands in S with pending=1. Write wins the pending flag.
- Arithmetic: all unsigned, DIV_W bits; cnt never exceeds D−1, so there is no overflow.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- While enabled, each channel's period is exactly D enabled cycles.
  - div_clk is high for floor(D/2) cycles and low for ceil(D/2). D=2 toggles every cycle; odd D gives a 1-cycle-longer low phase.
  - tick is high for exactly 1 cycle per period. It is asserted in the cycle after the edge where cnt = D−1.
- After reset release with en=1: first tick follows the D-th rising edge; div_clk goes high after the first edge.
- Divisor update latency: takes effect at the first wrap (or sync_all) after the write. The in-flight period always completes with the old D, so there are no runt or stretched pulses.
- pending rises the cycle after the write. It falls the cycle after the transferring wrap or sync.
- sync_all: the next tick on every enabled channel follows D enabled edges after the sync edge. Channels with equal D tick in the same cycle.
- Reset mid-period: all outputs are 0 in the cycle after the reset edge, and any pending write is discarded.

## Test plan

Bench parameters: N_CH=2, DIV_W=8, DEFAULT_DIV=10.

1. Reset, then en=2'b11 for 40 cycles -> tick pulses every 10 cycles on both channels; first pulse after edge 10. div_clk is 5 high / 5 low, period 10.
2. Write ch1 wr_div=4 when ch1 cnt=3 -> ch1 finishes its 10-cycle period with pending=1. After that wrap, ch1 period is 4 (2 high / 2 low) and pending=0. ch0 is unaffected.
3. Write ch0 wr_div=0, then wr_ch=3 with wr_div=7 -> the first write is clamped to 2, so after the next wrap ch0 div_clk toggles every cycle and tick every 2. The out-of-range write changes nothing.
4. Drop en[0] for 7 cycles mid-period -> ch0 div_clk holds its level and tick is 0. The next tick is delayed by exactly 7 cycles versus ch1.
5. ch0 D=10, ch1 D=5, phases offset; assert sync_all for one cycle with ch1 write pending (S=10) -> both cnt reset and ch1 adopts D=10. Both ticks coincide 10 edges later and every 10 cycles thereafter.
6. Assert reset mid-period with ch1 pending=1 -> next cycle div_clk=0, tick=0, pending=0. Both channels resume at period 10.

Source files
------------

// File: rtl/multi_clock_divider.sv
// N_CH independent programmable clock dividers with per-channel enable, shadowed
// divisor updates that take effect on wrap or sync, and registered div_clk/tick outputs.
module multi_clock_divider #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 28,
    parameter int DEFAULT_DIV = 100000,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   en,
    input  logic              sync_all,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic [N_CH-1:0]   div_clk,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

    // Divisors below 2 cannot produce a clock, so they are raised to 2.
    logic [DIV_W-1:0] div_clamped;
    assign div_clamped = (wr_div < MIN_DIV) ? MIN_DIV : wr_div;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] d_act;
        logic [DIV_W-1:0] d_shd;
        logic             pend;
        logic             div_r;
        logic             tick_r;
        logic             wr_hit;
        logic             at_wrap;

        assign wr_hit  = wr_en && (wr_ch == CH_W'(ch));
        assign at_wrap = (cnt >= (d_act - DIV_W'(1)));

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                d_act  <= DEF_DIV;
                d_shd  <= DEF_DIV;
                pend   <= 1'b0;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                if (sync_all) begin
                    cnt    <= '0;
                    div_r  <= 1'b0;
                    tick_r <= 1'b0;
                    if (pend) begin
                        d_act <= d_shd;
                        pend  <= 1'b0;
                    end
                end else if (en[ch]) begin
                    div_r <= (cnt < (d_act >> 1));
                    if (at_wrap) begin
                        cnt    <= '0;
                        tick_r <= 1'b1;
                        if (pend) begin
                            d_act <= d_shd;
                            pend  <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt + DIV_W'(1);
                        tick_r <= 1'b0;
                    end
                end else begin
                    tick_r <= 1'b0;
                end
                // A write on the same edge as a transfer re-arms pending with the new value.
                if (wr_hit) begin
                    d_shd <= div_clamped;
                    pend  <= 1'b1;
                end
            end
        end

        assign div_clk[ch] = div_r;
        assign tick[ch]    = tick_r;
        assign pending[ch] = pend;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed plus randomized bench for multi_clock_divider against a period-position
// reference model; a second 3-channel instance covers out-of-range channel writes.
module tb_multi_clock_divider;

    localparam int N_CH = 2;
    localparam int DIV_W = 8;
    localparam int DEF = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic [1:0]       en = 2'b00;
    logic             sync_all = 1'b0;
    logic             wr_en = 1'b0;
    logic             wr_ch = 1'b0;
    logic [7:0]       wr_div = 8'd0;
    logic [1:0]       div_clk, tick, pending;

    logic             reset3 = 1'b1;
    logic             wr_en3 = 1'b0;
    logic [1:0]       wr_ch3 = 2'd0;
    logic [2:0]       div_clk3, tick3, pending3;

    int tests = 0;
    int fails = 0;

    // Reference: position within the current period, active and shadow divisors.
    int         m_pos [N_CH];
    int         m_d   [N_CH];
    int         m_s   [N_CH];
    logic [1:0] m_pend, m_div, m_tick;

    multi_clock_divider #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sync_all(sync_all),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .div_clk(div_clk), .tick(tick), .pending(pending)
    );

    multi_clock_divider #(.N_CH(3), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) u_dut3 (
        .clk(clk), .reset(reset3), .en(3'b111), .sync_all(1'b0),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_div(wr_div),
        .div_clk(div_clk3), .tick(tick3), .pending(pending3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                m_pos[i] = 0;
                m_d[i]   = DEF;
                m_s[i]   = DEF;
            end
            m_pend = '0;
            m_div  = '0;
            m_tick = '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                bit hit;
                hit = wr_en && (int'(wr_ch) == i);
                if (sync_all) begin
                    m_pos[i]  = 0;
                    m_div[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                    if (m_pend[i]) begin
                        m_d[i]    = m_s[i];
                        m_pend[i] = 1'b0;
                    end
                end else if (en[i]) begin
                    m_div[i] = (m_pos[i] < m_d[i] / 2);
                    if (m_pos[i] == m_d[i] - 1) begin
                        m_pos[i]  = 0;
                        m_tick[i] = 1'b1;
                        if (m_pend[i]) begin
                            m_d[i]    = m_s[i];
                            m_pend[i] = 1'b0;
                        end
                    end else begin
                        m_pos[i]  = m_pos[i] + 1;
                        m_tick[i] = 1'b0;
                    end
                end else begin
                    m_tick[i] = 1'b0;
                end
                if (hit) begin
                    m_s[i]    = (wr_div < 2) ? 2 : int'(wr_div);
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("div_clk", 8'(div_clk), 8'(m_div));
        chk("tick", 8'(tick), 8'(m_tick));
        chk("pending", 8'(pending), 8'(m_pend));
    endtask

    task automatic write(input logic ch, input logic [7:0] val);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = val;
        step();
        wr_en  = 1'b0;
    endtask

    initial begin
        int k;

        // Reset state
        step();
        step();
        chk("rst_div", 8'(div_clk), 8'd0);
        chk("rst_tick", 8'(tick), 8'd0);
        chk("rst_pend", 8'(pending), 8'd0);

        // Free running at default divisor: ticks on edges 10, 20, 30, 40
        reset = 1'b0;
        en    = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c % 10 == 0) chk("default_tick", 8'(tick), 8'b11);
            if (c == 1) chk("first_div_high", 8'(div_clk), 8'b11);
        end

        // Write ch1 divisor 4 when its counter reads 3
        k = 0;
        while (m_pos[1] != 3 && k < 20) begin
            step();
            k++;
        end
        chk("wait_pos3", 8'(k < 20), 8'd1);
        write(1'b1, 8'd4);
        chk("pend_rise", 8'(pending[1]), 8'd1);
        repeat (20) step();

        // Clamp of divisor 0 on ch0
        write(1'b0, 8'd0);
        repeat (16) step();

        // Restore ch0=10, ch1=5
        write(1'b0, 8'd10);
        write(1'b1, 8'd5);
        repeat (14) step();

        // Pause ch0 for 7 cycles
        en = 2'b10;
        repeat (7) step();
        en = 2'b11;
        repeat (20) step();

        // Sync with ch1 write pending: both channels tick together 10 edges later
        write(1'b1, 8'd10);
        sync_all = 1'b1;
        step();
        sync_all = 1'b0;
        chk("sync_pend_clear", 8'(pending), 8'd0);
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("sync_tick", 8'(tick), (c == 10) ? 8'b11 : 8'b00);
        end
        repeat (20) step();

        // Reset mid-period with a write pending
        repeat (3) step();
        write(1'b1, 8'd6);
        reset = 1'b1;
        step();
        chk("midrst_div", 8'(div_clk), 8'd0);
        chk("midrst_tick", 8'(tick), 8'd0);
        chk("midrst_pend", 8'(pending), 8'd0);
        reset = 1'b0;
        repeat (30) step();

        // Out-of-range channel write on the 3-channel instance
        reset3 = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            wr_en3 = (c == 3);
            wr_ch3 = 2'd3;
            wr_div = 8'd3;
            step();
            chk("oor_pend", 8'(pending3), 8'd0);
            chk("oor_tick", 8'(tick3), (c % 10 == 0) ? 8'b111 : 8'b000);
            chk("oor_div", 8'(div_clk3), (((c - 1) % 10) < 5) ? 8'b111 : 8'b000);
        end
        wr_en3 = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_ch    = 1'($urandom_range(0, 1));
            wr_div   = 8'($urandom_range(0, 12));
            sync_all = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            step();
        end
        wr_en    = 1'b0;
        sync_all = 1'b0;
        reset    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
